// File: rtl/fe_capture_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fe_capture_param : front-end byte/status capture into timestamped records |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fe_capture_param #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pSTAT_WIDTH        = 5,
  parameter int pSHORT_TS_WIDTH    = 3,
  parameter int pFULL_TS_WIDTH     = 16,
  parameter int pCAPTURE_LEN_WIDTH = 24,
  parameter int pDROP_CNT_WIDTH    = 16
) (
  input  logic                                                        fe_clk,
  input  logic                                                        reset_n,
  input  logic [pDATA_WIDTH-1:0]                                      fe_data,
  input  logic                                                        fe_rxvalid,
  input  logic [pSTAT_WIDTH-1:0]                                      fe_status,
  input  logic                                                        I_arm,
  input  logic                                                        I_capture_enable,
  input  logic [pCAPTURE_LEN_WIDTH-1:0]                               I_capture_len,
  input  logic [1:0]                                                  I_mode,
  input  logic                                                        I_timestamps_disable,
  input  logic                                                        I_fifo_full,
  output logic                                                        O_fifo_wr,
  output logic [2+pSHORT_TS_WIDTH+pDATA_WIDTH+pSTAT_WIDTH-1:0]        O_fifo_data,
  output logic                                                        O_capturing,
  output logic                                                        O_capture_done,
  output logic [pDROP_CNT_WIDTH-1:0]                                  O_drop_count,
  output logic                                                        O_overflow,
  output logic [pDATA_WIDTH-1:0]                                      O_pm_data,
  output logic                                                        O_pm_wr
);

  localparam int REC_W = 2 + pSHORT_TS_WIDTH + pDATA_WIDTH + pSTAT_WIDTH;

  localparam logic [1:0] CMD_DATA       = 2'b00;
  localparam logic [1:0] CMD_TIME       = 2'b01;
  localparam logic [1:0] CMD_STAT       = 2'b10;
  localparam logic [1:0] MODE_DATA_ONLY = 2'd1;
  localparam logic [1:0] MODE_STAT_ONLY = 2'd2;

  localparam logic [pFULL_TS_WIDTH-1:0] SHORT_MAX =
    {{(pFULL_TS_WIDTH-pSHORT_TS_WIDTH){1'b0}}, {pSHORT_TS_WIDTH{1'b1}}};
  localparam logic [pFULL_TS_WIDTH-1:0] FULL_LAST = {{(pFULL_TS_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [pFULL_TS_WIDTH-1:0] IDLE_ONE  = {{(pFULL_TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pCAPTURE_LEN_WIDTH-1:0] LEN_ONE = {{(pCAPTURE_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pDROP_CNT_WIDTH-1:0] DROP_ONE   = {{(pDROP_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t                          state_q;
  logic [pDATA_WIDTH-1:0]          data_q;
  logic                            rxvalid_q;
  logic [pSTAT_WIDTH-1:0]          status_q;
  logic [pSTAT_WIDTH-1:0]          status_prev_q;
  logic [pCAPTURE_LEN_WIDTH-1:0]   rec_cnt_q;
  logic [pFULL_TS_WIDTH-1:0]       idle_q;
  logic [pFULL_TS_WIDTH-1:0]       idle_d;
  logic [pDROP_CNT_WIDTH-1:0]      drop_q;
  logic                            done_q;
  logic                            ovf_q;
  logic                            wr_q;
  logic [REC_W-1:0]                rec_q;
  logic [REC_W-1:0]                rec_d;

  logic                            data_ok;
  logic                            stat_ok;
  logic                            raw_ev;
  logic                            d_data_ev;
  logic                            d_ev;
  logic                            capturing;
  logic                            gen;
  logic [pCAPTURE_LEN_WIDTH-1:0]   cnt_inc;
  logic [pDROP_CNT_WIDTH-1:0]      drop_inc;

  assign data_ok   = (I_mode != MODE_STAT_ONLY);
  assign stat_ok   = (I_mode != MODE_DATA_ONLY);
  assign raw_ev    = (fe_rxvalid && data_ok) || ((fe_status != status_q) && stat_ok);
  assign d_data_ev = rxvalid_q && data_ok;
  assign d_ev      = d_data_ev || ((status_q != status_prev_q) && stat_ok);
  assign capturing = (state_q == ST_ARMED) && I_capture_enable &&
                     ((rec_cnt_q < I_capture_len) || (I_capture_len == '0));
  assign cnt_inc   = (rec_cnt_q == '1) ? rec_cnt_q : rec_cnt_q + LEN_ONE;
  assign drop_inc  = (drop_q == '1) ? drop_q : drop_q + DROP_ONE;

  // An upcoming raw event that would overflow the short time field is preceded
  // by a TIME record, so the stage-D record after it always carries time 0.
  always_comb begin
    rec_d  = '0;
    gen    = 1'b0;
    idle_d = idle_q;
    if (capturing) begin
      if (d_ev) begin
        gen                                   = 1'b1;
        rec_d[1:0]                            = d_data_ev ? CMD_DATA : CMD_STAT;
        rec_d[2 +: pSHORT_TS_WIDTH]           = I_timestamps_disable ? '0 : idle_q[pSHORT_TS_WIDTH-1:0];
        if (d_data_ev) begin
          rec_d[2+pSHORT_TS_WIDTH +: pDATA_WIDTH] = data_q;
        end
        rec_d[REC_W-1 -: pSTAT_WIDTH]         = status_q;
        idle_d                                = '0;
      end else if (I_timestamps_disable) begin
        idle_d = '0;
      end else if ((raw_ev && (idle_q >= SHORT_MAX)) || (idle_q == FULL_LAST)) begin
        gen                        = 1'b1;
        rec_d[1:0]                 = CMD_TIME;
        rec_d[2 +: pFULL_TS_WIDTH] = idle_q + IDLE_ONE;
        idle_d                     = '0;
      end else begin
        idle_d = idle_q + IDLE_ONE;
      end
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      data_q        <= '0;
      rxvalid_q     <= 1'b0;
      status_q      <= '0;
      status_prev_q <= '0;
      rec_cnt_q     <= '0;
      idle_q        <= '0;
      drop_q        <= '0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      wr_q          <= 1'b0;
      rec_q         <= '0;
    end else begin
      data_q        <= fe_data;
      rxvalid_q     <= fe_rxvalid;
      status_q      <= fe_status;
      status_prev_q <= status_q;
      if (I_arm) begin
        state_q   <= ST_ARMED;
        rec_cnt_q <= '0;
        idle_q    <= '0;
        drop_q    <= '0;
        done_q    <= 1'b0;
        ovf_q     <= 1'b0;
        wr_q      <= 1'b0;
      end else begin
        idle_q <= idle_d;
        wr_q   <= gen && !I_fifo_full;
        if (gen) begin
          rec_cnt_q <= cnt_inc;
          if ((I_capture_len != '0) && (cnt_inc == I_capture_len)) begin
            done_q <= 1'b1;
          end
          // Dropped records still count toward the limit.
          if (I_fifo_full) begin
            drop_q <= drop_inc;
            ovf_q  <= 1'b1;
          end else begin
            rec_q <= rec_d;
          end
        end
      end
    end
  end

  assign O_fifo_wr      = wr_q;
  assign O_fifo_data    = rec_q;
  assign O_capturing    = capturing;
  assign O_capture_done = done_q;
  assign O_drop_count   = drop_q;
  assign O_overflow     = ovf_q;
  assign O_pm_data      = data_q;
  assign O_pm_wr        = rxvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_fe_capture_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fe_capture_param : directed self-checking bench for fe_capture_param  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fe_capture_param;

  logic        fe_clk;
  logic        reset_n;
  logic [7:0]  fe_data;
  logic        fe_rxvalid;
  logic [4:0]  fe_status;
  logic        I_arm;
  logic        I_capture_enable;
  logic [23:0] I_capture_len;
  logic [1:0]  I_mode;
  logic        I_timestamps_disable;
  logic        I_fifo_full;
  logic        O_fifo_wr;
  logic [17:0] O_fifo_data;
  logic        O_capturing;
  logic        O_capture_done;
  logic [15:0] O_drop_count;
  logic        O_overflow;
  logic [7:0]  O_pm_data;
  logic        O_pm_wr;

  int          n_tests;
  int          n_fail;
  int          wr_cnt;
  int          base;
  int          n;
  logic [17:0] last_rec;

  fe_capture_param dut (
    .fe_clk               (fe_clk),
    .reset_n              (reset_n),
    .fe_data              (fe_data),
    .fe_rxvalid           (fe_rxvalid),
    .fe_status            (fe_status),
    .I_arm                (I_arm),
    .I_capture_enable     (I_capture_enable),
    .I_capture_len        (I_capture_len),
    .I_mode               (I_mode),
    .I_timestamps_disable (I_timestamps_disable),
    .I_fifo_full          (I_fifo_full),
    .O_fifo_wr            (O_fifo_wr),
    .O_fifo_data          (O_fifo_data),
    .O_capturing          (O_capturing),
    .O_capture_done       (O_capture_done),
    .O_drop_count         (O_drop_count),
    .O_overflow           (O_overflow),
    .O_pm_data            (O_pm_data),
    .O_pm_wr              (O_pm_wr)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  always @(posedge fe_clk) begin
    #1;
    if (O_fifo_wr === 1'b1) begin
      wr_cnt   = wr_cnt + 1;
      last_rec = O_fifo_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge fe_clk);
  endtask

  task automatic arm();
    I_arm = 1'b1;
    step(1);
    I_arm = 1'b0;
  endtask

  function automatic logic [17:0] mk_rec(input logic [1:0] cmd, input logic [2:0] ts,
                                         input logic [7:0] d, input logic [4:0] st);
    return {st, d, ts, cmd};
  endfunction

  function automatic logic [17:0] mk_time(input logic [15:0] v);
    return {v, 2'b01};
  endfunction

  task automatic exp_rec(input string tag, input logic [17:0] exp);
    chk({tag, "_wr"}, {31'd0, O_fifo_wr}, 32'd1);
    chk({tag, "_data"}, {14'd0, O_fifo_data}, {14'd0, exp});
  endtask

  initial begin
    n_tests = 0; n_fail = 0; wr_cnt = 0; last_rec = '0;
    reset_n = 1'b0; fe_data = '0; fe_rxvalid = 1'b0; fe_status = '0;
    I_arm = 1'b0; I_capture_enable = 1'b1; I_capture_len = '0; I_mode = 2'd0;
    I_timestamps_disable = 1'b0; I_fifo_full = 1'b0;
    step(2);
    chk("rst_wr", {31'd0, O_fifo_wr}, 32'd0);
    chk("rst_capturing", {31'd0, O_capturing}, 32'd0);
    chk("rst_drop", {16'd0, O_drop_count}, 32'd0);
    chk("rst_pm_wr", {31'd0, O_pm_wr}, 32'd0);
    reset_n = 1'b1;
    step(1);

    // No writes before the first arm
    base = wr_cnt;
    fe_data = 8'h11; fe_rxvalid = 1'b1;
    step(3);
    fe_rxvalid = 1'b0;
    step(3);
    chk("no_wr_before_arm", wr_cnt - base, 32'd0);

    // Byte three cycles after arm: one DATA record two edges after the strobe
    arm();
    step(2);
    fe_data = 8'hA5; fe_rxvalid = 1'b1; fe_status = 5'h01;
    step(1);
    fe_rxvalid = 1'b0;
    chk("t3_wr_early", {31'd0, O_fifo_wr}, 32'd0);
    chk("pm_wr", {31'd0, O_pm_wr}, 32'd1);
    chk("pm_data", {24'd0, O_pm_data}, 32'hA5);
    step(1);
    exp_rec("t3_rec", mk_rec(2'b00, 3'd3, 8'hA5, 5'h01));
    step(1);
    chk("t3_single", {31'd0, O_fifo_wr}, 32'd0);

    // Long idle: TIME 20 then DATA records with time 0
    arm();
    step(19);
    fe_data = 8'h3C; fe_rxvalid = 1'b1;
    step(1);
    exp_rec("carry_time", mk_time(16'd20));
    fe_data = 8'h3D;
    step(1);
    exp_rec("carry_d0", mk_rec(2'b00, 3'd0, 8'h3C, 5'h01));
    fe_data = 8'h3E;
    step(1);
    exp_rec("carry_d1", mk_rec(2'b00, 3'd0, 8'h3D, 5'h01));
    fe_rxvalid = 1'b0;
    step(1);
    exp_rec("carry_d2", mk_rec(2'b00, 3'd0, 8'h3E, 5'h01));

    // Record limit of 4
    I_capture_len = 24'd4;
    arm();
    chk("len_capturing", {31'd0, O_capturing}, 32'd1);
    base = wr_cnt;
    fe_rxvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fe_data = 8'(i);
      step(1);
    end
    fe_rxvalid = 1'b0;
    step(4);
    chk("len_writes", wr_cnt - base, 32'd4);
    chk("len_capturing_off", {31'd0, O_capturing}, 32'd0);
    chk("len_done", {31'd0, O_capture_done}, 32'd1);

    // FIFO full drops
    I_capture_len = '0;
    I_fifo_full = 1'b1;
    arm();
    chk("arm_clears_done", {31'd0, O_capture_done}, 32'd0);
    base = wr_cnt;
    fe_rxvalid = 1'b1;
    step(3);
    fe_rxvalid = 1'b0;
    step(4);
    chk("full_no_wr", wr_cnt - base, 32'd0);
    chk("full_drop", {16'd0, O_drop_count}, 32'd3);
    chk("full_ovf", {31'd0, O_overflow}, 32'd1);
    I_fifo_full = 1'b0;
    arm();
    chk("arm_clr_drop", {16'd0, O_drop_count}, 32'd0);
    chk("arm_clr_ovf", {31'd0, O_overflow}, 32'd0);

    // Mode filtering
    I_mode = 2'd1;
    arm();
    base = wr_cnt;
    fe_status = 5'h02;
    step(3);
    fe_status = 5'h00;
    step(3);
    chk("mode1_stat_only", wr_cnt - base, 32'd0);
    I_mode = 2'd2;
    base = wr_cnt;
    fe_rxvalid = 1'b1;
    step(3);
    fe_rxvalid = 1'b0;
    step(3);
    chk("mode2_bytes_only", wr_cnt - base, 32'd0);
    arm();
    step(1);
    fe_status = 5'h04;
    step(2);
    exp_rec("stat_rec", mk_rec(2'b10, 3'd2, 8'h00, 5'h04));

    // Timestamps disabled
    I_mode = 2'd0;
    I_timestamps_disable = 1'b1;
    arm();
    step(20);
    base = wr_cnt;
    fe_data = 8'h5A; fe_rxvalid = 1'b1;
    step(1);
    fe_rxvalid = 1'b0;
    step(3);
    chk("tsdis_count", wr_cnt - base, 32'd1);
    chk("tsdis_rec", {14'd0, last_rec}, {14'd0, mk_rec(2'b00, 3'd0, 8'h5A, 5'h04)});
    I_timestamps_disable = 1'b0;

    // Idle counter wrap emits an all-ones TIME record
    arm();
    base = wr_cnt;
    n = 0;
    while (wr_cnt == base && n < 70000) begin
      step(1);
      n = n + 1;
    end
    chk("full_time_cycles", n, 32'd65535);
    chk("full_time_rec", {14'd0, last_rec}, {14'd0, mk_time(16'hFFFF)});

    // Asynchronous reset mid-capture
    I_fifo_full = 1'b1;
    arm();
    fe_data = 8'h77; fe_rxvalid = 1'b1;
    step(2);
    I_fifo_full = 1'b0;
    @(posedge fe_clk);
    #2;
    chk("pre_rst_wr", {31'd0, O_fifo_wr}, 32'd1);
    chk("pre_rst_drop", {16'd0, O_drop_count}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_wr", {31'd0, O_fifo_wr}, 32'd0);
    chk("arst_capturing", {31'd0, O_capturing}, 32'd0);
    chk("arst_drop", {16'd0, O_drop_count}, 32'd0);
    chk("arst_ovf", {31'd0, O_overflow}, 32'd0);
    chk("arst_pm_wr", {31'd0, O_pm_wr}, 32'd0);
    chk("arst_data", {14'd0, O_fifo_data}, 32'd0);
    step(1);
    reset_n = 1'b1;
    base = wr_cnt;
    step(5);
    fe_rxvalid = 1'b0;
    step(2);
    chk("post_rst_no_wr", wr_cnt - base, 32'd0);
    arm();
    fe_data = 8'h88; fe_rxvalid = 1'b1;
    step(1);
    fe_rxvalid = 1'b0;
    step(3);
    chk("post_rst_arm_wr", wr_cnt - base, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fe_capture_param.md
FE_CAPTURE_PARAM -- requirements
Module: fe_capture_param

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 8, front-end data byte width.
REQ-002 SHALL have parameter pSTAT_WIDTH, default 5, front-end status bit count.
REQ-003 SHALL have parameter pSHORT_TS_WIDTH, default 3, time field width in DATA/STAT records.
REQ-004 SHALL have parameter pFULL_TS_WIDTH, default 16, idle counter and TIME record width; legal only if pSHORT_TS_WIDTH < pFULL_TS_WIDTH <= pSHORT_TS_WIDTH+pDATA_WIDTH+pSTAT_WIDTH.
REQ-005 SHALL have parameter pCAPTURE_LEN_WIDTH, default 24, record-limit width.
REQ-006 SHALL have parameter pDROP_CNT_WIDTH, default 16, dropped-record counter width.
REQ-007 SHALL have one clock and asynchronous active-low reset: fe_clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: fe_data  in  pDATA_WIDTH  byte; fe_rxvalid  in  1  byte strobe; fe_status  in  pSTAT_WIDTH  status bits.
REQ-009 SHALL have ports: I_arm  in  1  one-cycle arm pulse; I_capture_enable  in  1  gate; I_capture_len  in  pCAPTURE_LEN_WIDTH  record limit (0 = unlimited); I_mode  in  2  event select; I_timestamps_disable  in  1; I_fifo_full  in  1.
REQ-010 SHALL have outputs: O_fifo_wr  out  1; O_fifo_data  out  W=2+pSHORT_TS_WIDTH+pDATA_WIDTH+pSTAT_WIDTH  record; O_capturing  out  1; O_capture_done  out  1; O_drop_count  out  pDROP_CNT_WIDTH; O_overflow  out  1; O_pm_data  out  pDATA_WIDTH; O_pm_wr  out  1.

Function
REQ-011 Record layout SHALL be: [1:0] cmd (00 DATA, 01 TIME, 10 STAT); [2 +: pSHORT_TS_WIDTH] time; next pDATA_WIDTH data; top pSTAT_WIDTH status. TIME records SHALL carry the value in [2 +: pFULL_TS_WIDTH] and zeros above.
REQ-012 Inputs SHALL be registered once (stage D); raw event = fe_rxvalid, or fe_status != stage-D status; detection on stage D uses the same rule one cycle later.
REQ-013 I_mode: 0 = data and status events; 1 = data only; 2 = status only; 3 SHALL behave as 0.
REQ-014 Data event with simultaneous status change SHALL produce one DATA record; every DATA/STAT record carries current stage-D status; STAT data field SHALL be 0.
REQ-015 Armed state SHALL begin on I_arm: record count, idle counter, O_drop_count, O_overflow cleared, O_capture_done cleared; I_arm while capturing restarts.
REQ-016 O_capturing SHALL be armed & I_capture_enable & (count < I_capture_len or I_capture_len == 0); records SHALL be generated only while O_capturing.
REQ-017 Idle counter SHALL count capturing cycles with no stage-D event, reset to 0 on each stage-D event record; it SHALL not count while not capturing.
REQ-018 Stage-D event SHALL produce its record with time = idle counter (low pSHORT_TS_WIDTH bits) on the following edge (O_fifo_wr two edges after fe_rxvalid sampled).
REQ-019 If a raw event is seen while idle counter >= 2^pSHORT_TS_WIDTH-1, a TIME record with value counter+1 SHALL be emitted that cycle and counter cleared, so the following event record carries time 0.
REQ-020 If idle counter reaches all-ones with no raw event, a TIME record of all-ones SHALL be emitted and counter cleared (no saturation loss).
REQ-021 At most one record SHALL be written per cycle; REQ-019 timing guarantees TIME never collides with an event record.
REQ-022 I_timestamps_disable=1 SHALL force all time fields to 0 and suppress TIME records.
REQ-023 Each generated record SHALL increment count (TIME included); O_capture_done SHALL assert the cycle count reaches a nonzero I_capture_len and hold until I_arm.
REQ-024 Record generated while I_fifo_full=1 SHALL not be written; O_drop_count SHALL increment saturating; O_overflow SHALL set sticky; dropped records SHALL still count toward the limit.
REQ-025 O_pm_data/O_pm_wr SHALL follow fe_data/fe_rxvalid with one-cycle latency regardless of arm/mode.

Reset
REQ-026 reset_n low SHALL immediately clear all registers and outputs to 0, including stage-D status, armed state, counters.
REQ-027 After reset release, no record SHALL be written until I_arm.

Verification
REQ-028 Arm, 3 idle cycles, byte 0xA5 with status 0x01 -> single record cmd 00, time 3, data 0xA5, status 0x01, two edges after strobe.
REQ-029 Arm, 20 idle cycles, byte 0x3C -> TIME record value 20, next cycle DATA time 0 data 0x3C; back-to-back bytes after carry time 0.
REQ-030 I_capture_len=4, 10 back-to-back bytes -> exactly 4 writes, O_capturing low after 4th, O_capture_done=1.
REQ-031 I_fifo_full=1 over 3 bytes -> no O_fifo_wr, O_drop_count=3, O_overflow=1; I_arm clears both.
REQ-032 I_mode=1 with status toggles only -> no records; I_mode=2 with bytes only -> none; status 0x00->0x04 -> STAT record, data 0.
REQ-033 reset_n low mid-capture -> all outputs 0 asynchronously; no writes after release until I_arm.
